// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   state_t   : arbiter FSM states (IDLE -> EXEC -> RESP -> IDLE)
//   ALUC_*    : 4-bit ALU opcodes understood by the shared alu datapath
//   alu_op_t  : one latched ALU operation (operands plus opcode)
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // aluc[1:0] picks the operation family, aluc[2] the variant,
  // aluc[3] turns a right shift into an arithmetic one.
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU.
//   a, b : operands (for shifts a[4:0] is the amount, b the shifted value)
//   aluc : opcode, see ALUC_* in alu_arb_pkg
//   r    : result, add/sub wrap modulo 2^32
//   z    : 1 when r is all zeros
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] r,
  output logic        z
);

  always_comb begin
    r = '0;
    case (aluc[1:0])
      2'b00:   r = aluc[2] ? (a - b) : (a + b);
      2'b01:   r = aluc[2] ? (a | b) : (a & b);
      2'b10:   r = aluc[2] ? {b[15:0], 16'h0000} : (a ^ b);
      default: begin
        if (!aluc[2])     r = b << a[4:0];
        else if (aluc[3]) r = $signed(b) >>> a[4:0];
        else              r = b >> a[4:0];
      end
    endcase
  end

  assign z = (r == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU.
// One operation is in flight at a time: accept in IDLE, compute in EXEC,
// hold the registered result in RESP until the granted requester takes it.
//   clk, clrn               : clock, asynchronous active-low reset
//   reqN_valid / reqN_ready : request handshake (ready only in IDLE)
//   reqN_a, reqN_b, reqN_aluc : operands and opcode of requester N
//   rspN_valid / rspN_ready : response handshake for requester N
//   rsp_r, rsp_z            : registered result and zero flag (shared)
//   busy                    : high whenever an operation is in flight
// RR_EN = 1 alternates grants on a tie; RR_EN = 0 always favours requester 0.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req0_aluc,
  input  logic [3:0]  req1_aluc,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_r,
  output logic        rsp_z,
  output logic        busy
);

  state_t  state_q, state_d;
  alu_op_t op_q;
  logic    grant_q;     // requester owning the in-flight operation
  logic    last_grant;  // requester granted most recently
  logic    grant_sel;
  logic    accept;
  logic    rsp_take;
  logic [31:0] alu_r;
  logic        alu_z;

  alu u_alu (
    .a    (op_q.a),
    .b    (op_q.b),
    .aluc (op_q.aluc),
    .r    (alu_r),
    .z    (alu_z)
  );

  assign rsp_take = grant_q ? rsp1_ready : rsp0_ready;

  // NOTE: every output of this block gets a default before the case;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    grant_sel  = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept = 1'b1;
          if (req0_valid && req1_valid) grant_sel = RR_EN ? ~last_grant : 1'b0;
          else                          grant_sel = req1_valid;
          req0_ready = ~grant_sel;
          req1_ready = grant_sel;
          state_d    = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      op_q       <= '0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;  // requester 0 wins the first tie
      rsp_r      <= '0;
      rsp_z      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= grant_sel ? alu_op_t'{req1_a, req1_b, req1_aluc}
                                : alu_op_t'{req0_a, req0_b, req0_aluc};
        grant_q    <= grant_sel;
        last_grant <= grant_sel;
      end
      if (state_q == EXEC) begin
        rsp_r <= alu_r;
        rsp_z <= alu_z;
      end
    end
  end

  assign rsp0_valid = (state_q == RESP) && !grant_q;
  assign rsp1_valid = (state_q == RESP) &&  grant_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin grant, 0 = fixed priority to requester 0.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port clrn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  operation request.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1  request accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  ALU operands.
REQ-007 SHALL have ports req0_aluc, req1_aluc  input  4  ALU opcode, standard ALU encoding.
REQ-008 SHALL have ports rsp0_valid, rsp1_valid  output  1  result available for that requester.
REQ-009 SHALL have ports rsp0_ready, rsp1_ready  input  1  requester consumes result.
REQ-010 SHALL have port rsp_r  output  32  registered ALU result, shared by both responses.
REQ-011 SHALL have port rsp_z  output  1  registered zero flag.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-014 In IDLE with any reqN_valid high, SHALL grant one requester, assert only its reqN_ready combinationally that cycle, latch its a/b/aluc and grant index, and go to EXEC.
REQ-015 In IDLE with no valid, SHALL stay in IDLE with both ready outputs low.
REQ-016 In EXEC, SHALL register the shared ALU's r and z from latched operands into rsp_r/rsp_z and go to RESP.
REQ-017 In RESP, SHALL assert rsp_valid only for the granted index and hold rsp_r/rsp_z stable until that rsp_ready is high, then go to IDLE.
REQ-018 Latency: request accepted at edge N, rsp valid from edge N+2; peak throughput one operation per 3 cycles.
REQ-019 With RR_EN=1 and both valid, SHALL grant the requester not granted last; the last-grant pointer updates at acceptance.
REQ-020 With RR_EN=0, SHALL always prefer requester 0 when both are valid.
REQ-021 SHALL never assert reqN_ready outside IDLE; requesters hold valid and operands until ready.
REQ-022 A requester dropping valid before ready SHALL not be granted that cycle.
REQ-023 ALU opcode semantics: aluc[1:0] 00 add/sub, 01 and/or, 10 xor/lui, 11 shift; aluc[2] selects sub/or/lui/right; aluc[3] arithmetic right shift; shift amount a[4:0], shifted value b.
REQ-024 rsp_z SHALL be 1 exactly when the 32-bit result is zero; add/sub wrap modulo 2^32, no overflow flag.

Reset
REQ-025 clrn low SHALL asynchronously force IDLE, both ready and rsp_valid outputs to 0, rsp_r to 0, rsp_z to 0, busy to 0, and the last-grant pointer to 1 so requester 0 wins the first tie.
REQ-026 Reset during EXEC or RESP SHALL discard the in-flight operation; no response is issued after reset release.

Structure
REQ-027 FSM state encoding and aluc opcode constants (ADD, SUB, AND, OR, XOR, LUI, SLL, SRL, SRA) SHALL live in shared package alu_arb_pkg.
REQ-028 SHALL instantiate the existing alu module exactly once as the shared datapath; no other sub-module.

Verification
REQ-029 req0: a=5, b=3, aluc=0000 accepted at edge N -> rsp0_valid at N+2, rsp_r=8, rsp_z=0.
REQ-030 Both valid after reset, RR_EN=1: req0 SUB a=7 b=7, req1 LUI b=0x1234 -> req0 first (r=0, z=1), then req1 (r=0x12340000, z=0).
REQ-031 rsp0_ready held low 5 cycles while req1_valid high -> rsp_r stable, req1_ready low throughout, req1 granted the cycle after RESP exits.
REQ-032 req1 SRA a=4, b=0x80000000, aluc=1111 -> rsp1 r=0xF8000000; SLL a=4, b=1, aluc=0011 -> r=0x10.
REQ-033 clrn pulsed low during EXEC -> no rsp_valid ever, busy=0, next request returns correct result with normal latency.
REQ-034 RR_EN=0, both valid continuously for 3 operations -> requester 0 granted all three, req1_ready stays 0.
